// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: receives scan-code set 2 frames and turns calculator
// keys into one-hot flags with a one-cycle kbd_ready strobe.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_0,
    output logic       key_1,
    output logic       key_2,
    output logic       key_3,
    output logic       key_4,
    output logic       key_5,
    output logic       key_6,
    output logic       key_7,
    output logic       key_8,
    output logic       key_9,
    output logic       key_plus,
    output logic       key_minus,
    output logic       key_equal,
    output logic       kbd_ready,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned NFLAGS = 13;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {DEC_WAIT, DEC_E0, DEC_F0, DEC_E0F0} dec_state_t;

    rx_state_t         rx_state, rx_next;
    dec_state_t        dec_state, dec_next;

    logic              clk_s1, clk_s2, clk_s3;
    logic              data_s1, data_s2;
    logic              fall_c;
    logic              shift_c, par_c, stop_c, timeout_c, frame_ok_c;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              par_bit;
    logic [TW-1:0]     timer;
    logic              byte_valid;
    logic [7:0]        rx_byte;

    logic              make_c, brk_c, ext_c, held_match_c;
    logic [7:0]        held_code;
    logic              held_ext;
    logic              held_valid;
    logic [NFLAGS-1:0] flags;

    // Index 0..9 digits, 10 plus, 11 minus, 12 equal.
    function automatic logic [NFLAGS-1:0] key_map(input logic [7:0] code, input logic ext);
        logic [NFLAGS-1:0] m;
        m = '0;
        if (ext) begin
            if (code == 8'h5A) m[12] = 1'b1;
        end else begin
            case (code)
                8'h45, 8'h70: m[0]  = 1'b1;
                8'h16, 8'h69: m[1]  = 1'b1;
                8'h1E, 8'h72: m[2]  = 1'b1;
                8'h26, 8'h7A: m[3]  = 1'b1;
                8'h25, 8'h6B: m[4]  = 1'b1;
                8'h2E, 8'h73: m[5]  = 1'b1;
                8'h36, 8'h74: m[6]  = 1'b1;
                8'h3D, 8'h6C: m[7]  = 1'b1;
                8'h3E, 8'h75: m[8]  = 1'b1;
                8'h46, 8'h7D: m[9]  = 1'b1;
                8'h79:        m[10] = 1'b1;
                8'h4E, 8'h7B: m[11] = 1'b1;
                8'h55, 8'h5A: m[12] = 1'b1;
                default:      m     = '0;
            endcase
        end
        return m;
    endfunction

    // Two-flop synchronisers plus one extra clock stage for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fall_c     = clk_s3 & ~clk_s2;
    assign frame_ok_c = (^{par_bit, shreg}) & data_s2;

    always_ff @(posedge clk) begin
        if (!reset_n) rx_state <= RX_IDLE;
        else          rx_state <= rx_next;
    end

    always_comb begin
        rx_next   = rx_state;
        shift_c   = 1'b0;
        par_c     = 1'b0;
        stop_c    = 1'b0;
        timeout_c = 1'b0;
        case (rx_state)
            RX_IDLE:   if (fall_c && !data_s2) rx_next = RX_DATA;
            RX_DATA:   if (fall_c) begin
                           shift_c = 1'b1;
                           if (bit_cnt == 3'd7) rx_next = RX_PARITY;
                       end
            RX_PARITY: if (fall_c) begin
                           par_c   = 1'b1;
                           rx_next = RX_STOP;
                       end
            RX_STOP:   if (fall_c) begin
                           stop_c  = 1'b1;
                           rx_next = RX_IDLE;
                       end
            default:   rx_next = RX_IDLE;
        endcase
        // Watchdog overrides any pending progress of a stalled frame.
        if (rx_state != RX_IDLE && !fall_c && timer == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_c = 1'b1;
            shift_c   = 1'b0;
            rx_next   = RX_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            timer      <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= stop_c & frame_ok_c;
            frame_err  <= (stop_c & ~frame_ok_c) | timeout_c;
            if (rx_state == RX_IDLE) bit_cnt <= 3'd0;
            else if (shift_c)        bit_cnt <= bit_cnt + 3'd1;
            if (shift_c) shreg   <= {data_s2, shreg[7:1]};
            if (par_c)   par_bit <= data_s2;
            if (stop_c && frame_ok_c) rx_byte <= shreg;
            if (rx_state == RX_IDLE || fall_c) timer <= '0;
            else                               timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) dec_state <= DEC_WAIT;
        else          dec_state <= dec_next;
    end

    always_comb begin
        dec_next = dec_state;
        make_c   = 1'b0;
        brk_c    = 1'b0;
        ext_c    = 1'b0;
        if (frame_err) begin
            dec_next = DEC_WAIT;
        end else if (byte_valid) begin
            case (dec_state)
                DEC_WAIT: begin
                    if (rx_byte == 8'hE0)      dec_next = DEC_E0;
                    else if (rx_byte == 8'hF0) dec_next = DEC_F0;
                    else                       make_c   = 1'b1;
                end
                DEC_E0: begin
                    ext_c = 1'b1;
                    if (rx_byte == 8'hF0) begin
                        dec_next = DEC_E0F0;
                    end else begin
                        make_c   = 1'b1;
                        dec_next = DEC_WAIT;
                    end
                end
                DEC_F0: begin
                    brk_c    = 1'b1;
                    dec_next = DEC_WAIT;
                end
                DEC_E0F0: begin
                    ext_c    = 1'b1;
                    brk_c    = 1'b1;
                    dec_next = DEC_WAIT;
                end
                default: dec_next = DEC_WAIT;
            endcase
        end
    end

    assign held_match_c = held_valid && (held_code == rx_byte) && (held_ext == ext_c);

    // Typematic repeats of the held key are swallowed; breaks only release it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags      <= '0;
            kbd_ready  <= 1'b0;
            scan_code  <= 8'h00;
            held_code  <= 8'h00;
            held_ext   <= 1'b0;
            held_valid <= 1'b0;
        end else begin
            kbd_ready <= 1'b0;
            if (make_c && !held_match_c) begin
                held_code  <= rx_byte;
                held_ext   <= ext_c;
                held_valid <= 1'b1;
                scan_code  <= rx_byte;
                flags      <= key_map(rx_byte, ext_c);
                kbd_ready  <= 1'b1;
            end
            if (brk_c && held_match_c) held_valid <= 1'b0;
        end
    end

    assign key_0     = flags[0];
    assign key_1     = flags[1];
    assign key_2     = flags[2];
    assign key_3     = flags[3];
    assign key_4     = flags[4];
    assign key_5     = flags[5];
    assign key_6     = flags[6];
    assign key_7     = flags[7];
    assign key_8     = flags[8];
    assign key_9     = flags[9];
    assign key_plus  = flags[10];
    assign key_minus = flags[11];
    assign key_equal = flags[12];

endmodule
